i2c_slave: RTL and testbench

//  I2C target (slave) controller, oversampled by a single system clock. It decodes START/STOP,

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_sync_edge.sv | 37 +++
 rtl/i2c_slave.sv | 238 +++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C target: FSM state encodings and ACK/NACK bus levels.
package i2c_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ADDR      = 3'd1;
   localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
   localparam logic [2:0] ST_WR_DATA   = 3'd3;
   localparam logic [2:0] ST_WR_ACK    = 3'd4;
   localparam logic [2:0] ST_RD_DATA   = 3'd5;
   localparam logic [2:0] ST_RD_ACK    = 3'd6;
   localparam logic [2:0] ST_WAIT_STOP = 3'd7;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Pad-line synchronizer with rise/fall detect; resets to 1 so an idle bus shows no edge.
module i2c_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstb,
   input  logic line_in,
   output logic line_s,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              dly_q;
   logic              dly_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], line_in};
      dly_d  = sync_q[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         sync_q <= '1;
         dly_q  <= 1'b1;
      end else begin
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign line_s = sync_q[STAGES-1];
   assign rise   = line_s & ~dly_q;
   assign fall   = ~line_s & dly_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target controller: START/STOP decode, 7-bit address match, byte shift in/out,
// ACK generation and SCL stretching while the host is not ready.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR        = 7'h2A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       ready,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       r_w,
   output logic       data_vld,
   output logic       start,
   output logic       stop,
   input  logic       scl_in,
   output logic       scl_oe,
   input  logic       sda_in,
   output logic       sda_oe
);

   logic scl_s, scl_rise, scl_fall;
   logic sda_s, sda_rise, sda_fall;
   logic start_det, stop_det, rd_load;

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_out_q, data_out_d;
   logic       r_w_q, r_w_d;
   logic       data_vld_q, data_vld_d;
   logic       start_q, start_d;
   logic       stop_q, stop_d;
   logic       scl_oe_q, scl_oe_d;
   logic       sda_oe_q, sda_oe_d;
   logic       ack_on_q, ack_on_d;
   logic       hold_q, hold_d;

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
      .clk(clk), .rstb(rstb), .line_in(scl_in),
      .line_s(scl_s), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
      .clk(clk), .rstb(rstb), .line_in(sda_in),
      .line_s(sda_s), .rise(sda_rise), .fall(sda_fall)
   );

   assign start_det = sda_fall & scl_s;
   assign stop_det  = sda_rise & scl_s;

   // hold_q marks a stretch waiting for ready; SCL is released one clk after SDA is
   // set up so the target's own SDA change can never be seen as a START.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      data_out_d = data_out_q;
      r_w_d      = r_w_q;
      data_vld_d = 1'b0;
      start_d    = 1'b0;
      stop_d     = 1'b0;
      scl_oe_d   = scl_oe_q;
      sda_oe_d   = sda_oe_q;
      ack_on_d   = ack_on_q;
      hold_d     = hold_q;
      rd_load    = 1'b0;

      if (scl_oe_q && !hold_q) begin
         scl_oe_d = 1'b0;
      end

      if (stop_det) begin
         stop_d   = 1'b1;
         state_d  = ST_IDLE;
         scl_oe_d = 1'b0;
         sda_oe_d = 1'b0;
         ack_on_d = 1'b0;
         hold_d   = 1'b0;
      end else if (start_det) begin
         start_d  = 1'b1;
         state_d  = ST_ADDR;
         cnt_d    = 4'd0;
         scl_oe_d = 1'b0;
         sda_oe_d = 1'b0;
         ack_on_d = 1'b0;
         hold_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     ack_on_d = 1'b0;
                     if (shift_q[6:0] == ADDR) begin
                        r_w_d   = sda_s;
                        state_d = ST_ADDR_ACK;
                     end else begin
                        state_d = ST_WAIT_STOP;
                     end
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!ack_on_q) begin
                     sda_oe_d = ~ACK;
                     ack_on_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     ack_on_d = 1'b0;
                     if (r_w_q) begin
                        rd_load = 1'b1;
                     end else begin
                        state_d = ST_WR_DATA;
                        cnt_d   = 4'd0;
                     end
                  end
               end
            end
            ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     data_out_d = {shift_q[6:0], sda_s};
                     data_vld_d = 1'b1;
                     ack_on_d   = 1'b0;
                     state_d    = ST_WR_ACK;
                  end
               end
            end
            ST_WR_ACK: begin
               if (!ack_on_q && (scl_fall || hold_q)) begin
                  if (ready) begin
                     sda_oe_d = ~ACK;
                     ack_on_d = 1'b1;
                     hold_d   = 1'b0;
                  end else begin
                     scl_oe_d = 1'b1;
                     hold_d   = 1'b1;
                  end
               end else if (ack_on_q && scl_fall) begin
                  sda_oe_d = 1'b0;
                  ack_on_d = 1'b0;
                  state_d  = ST_WR_DATA;
                  cnt_d    = 4'd0;
               end
            end
            ST_RD_DATA: begin
               if (hold_q) begin
                  rd_load = 1'b1;
               end else if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     ack_on_d = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise && !ack_on_q) begin
                  if (sda_s == NACK) begin
                     state_d = ST_WAIT_STOP;
                  end else begin
                     ack_on_d = 1'b1;
                  end
               end else if (scl_fall && ack_on_q) begin
                  ack_on_d = 1'b0;
                  rd_load  = 1'b1;
               end
            end
            default: begin
            end
         endcase

         if (rd_load) begin
            state_d = ST_RD_DATA;
            if (ready) begin
               shift_d  = data_in;
               sda_oe_d = ~data_in[7];
               cnt_d    = 4'd0;
               hold_d   = 1'b0;
            end else begin
               scl_oe_d = 1'b1;
               hold_d   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         shift_q    <= 8'd0;
         data_out_q <= 8'd0;
         r_w_q      <= 1'b0;
         data_vld_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         scl_oe_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
         ack_on_q   <= 1'b0;
         hold_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         data_out_q <= data_out_d;
         r_w_q      <= r_w_d;
         data_vld_q <= data_vld_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         scl_oe_q   <= scl_oe_d;
         sda_oe_q   <= sda_oe_d;
         ack_on_q   <= ack_on_d;
         hold_q     <= hold_d;
      end
   end

   assign data_out = data_out_q;
   assign r_w      = r_w_q;
   assign data_vld = data_vld_q;
   assign start    = start_q;
   assign stop     = stop_q;
   assign scl_oe   = scl_oe_q;
   assign sda_oe   = sda_oe_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master on open-drain lines, with expected
// write bytes queued as they are sent and compared when data_vld fires.
module tb_i2c_slave;
   import i2c_pkg::*;

   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       rstb = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       r_w, data_vld, start, stop;
   logic       scl_oe, sda_oe;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       scl_line, sda_line;

   assign scl_line = scl_m & ~scl_oe;
   assign sda_line = sda_m & ~sda_oe;

   i2c_slave #(.ADDR(7'h2A), .SYNC_STAGES(2)) dut (
      .clk(clk), .rstb(rstb), .ready(ready), .data_in(data_in),
      .data_out(data_out), .r_w(r_w), .data_vld(data_vld),
      .start(start), .stop(stop),
      .scl_in(scl_line), .scl_oe(scl_oe),
      .sda_in(sda_line), .sda_oe(sda_oe)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         vld_cnt = 0;
   int         start_cnt = 0;
   int         stop_cnt = 0;
   logic       sda_oe_seen = 1'b0;
   logic [7:0] exp_q[$];

   // Every comparison goes through here so the counts and the report format stay uniform.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each data_vld and tallies start/stop pulses.
   always @(negedge clk) begin
      if (data_vld) begin
         vld_cnt++;
         checkOutput("data_vld_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
         if (exp_q.size() != 0) begin
            checkOutput("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
         end
      end
      if (start) start_cnt++;
      if (stop) stop_cnt++;
      if (sda_oe) sda_oe_seen = 1'b1;
   end

   task automatic waitClk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic raiseScl();
      int n;
      scl_m = 1'b1;
      n = 0;
      while (scl_line !== 1'b1 && n < 4000) begin
         waitClk(1);
         n++;
      end
      checkOutput("scl_release", {31'd0, scl_line}, 32'd1);
   endtask

   // One SCL period: master drives d (1 = release), samples the line mid-high into s.
   task automatic applyStimulus(input logic d, output logic s);
      sda_m = d;
      waitClk(Q);
      raiseScl();
      waitClk(Q / 2);
      s = sda_line;
      waitClk(Q / 2);
      scl_m = 1'b0;
      waitClk(Q);
   endtask

   task automatic startCond();
      sda_m = 1'b1;
      waitClk(Q);
      raiseScl();
      waitClk(Q);
      sda_m = 1'b0;
      waitClk(Q);
      scl_m = 1'b0;
      waitClk(Q);
   endtask

   task automatic stopCond();
      sda_m = 1'b0;
      waitClk(Q);
      raiseScl();
      waitClk(Q);
      sda_m = 1'b1;
      waitClk(Q);
   endtask

   task automatic writeByte(input logic [7:0] b, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) applyStimulus(b[i], dummy);
      applyStimulus(1'b1, ack);
   endtask

   task automatic readByte(input logic nack, output logic [7:0] b);
      logic dummy;
      for (int i = 7; i >= 0; i--) applyStimulus(1'b1, b[i]);
      applyStimulus(nack, dummy);
   endtask

   initial begin
      logic       ack;
      logic       bitv;
      logic [7:0] rd;
      int         v0, s0, p0, held;

      waitClk(3);
      rstb = 1'b0;
      waitClk(2);
      checkOutput("rst_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
      checkOutput("rst_data_out", {24'd0, data_out}, 32'd0);
      checkOutput("rst_r_w", {31'd0, r_w}, 32'd0);
      checkOutput("rst_data_vld", {31'd0, data_vld}, 32'd0);
      checkOutput("rst_start", {31'd0, start}, 32'd0);
      checkOutput("rst_stop", {31'd0, stop}, 32'd0);
      checkOutput("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
      checkOutput("rst_sda_oe", {31'd0, sda_oe}, 32'd0);

      $display("[TB] write 0x54 0xA5");
      v0 = vld_cnt; s0 = start_cnt; p0 = stop_cnt;
      exp_q.push_back(8'hA5);
      startCond();
      writeByte(8'h54, ack);
      checkOutput("t1_addr_ack", {31'd0, ack}, {31'd0, ACK});
      checkOutput("t1_r_w", {31'd0, r_w}, 32'd0);
      writeByte(8'hA5, ack);
      checkOutput("t1_data_ack", {31'd0, ack}, {31'd0, ACK});
      stopCond();
      waitClk(4);
      checkOutput("t1_vld_count", vld_cnt - v0, 32'd1);
      checkOutput("t1_start_count", start_cnt - s0, 32'd1);
      checkOutput("t1_stop_count", stop_cnt - p0, 32'd1);
      checkOutput("t1_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});

      $display("[TB] read 0x55 -> 0x3C");
      v0 = vld_cnt;
      data_in = 8'h3C;
      startCond();
      writeByte(8'h55, ack);
      checkOutput("t2_addr_ack", {31'd0, ack}, {31'd0, ACK});
      checkOutput("t2_r_w", {31'd0, r_w}, 32'd1);
      readByte(NACK, rd);
      checkOutput("t2_read_byte", {24'd0, rd}, 32'h3C);
      stopCond();
      waitClk(4);
      checkOutput("t2_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
      checkOutput("t2_vld_count", vld_cnt - v0, 32'd0);

      $display("[TB] address mismatch 0x56");
      v0 = vld_cnt; s0 = start_cnt; p0 = stop_cnt;
      sda_oe_seen = 1'b0;
      startCond();
      writeByte(8'h56, ack);
      checkOutput("t3_addr_nack", {31'd0, ack}, {31'd0, NACK});
      stopCond();
      waitClk(4);
      checkOutput("t3_sda_never_low", {31'd0, sda_oe_seen}, 32'd0);
      checkOutput("t3_vld_count", vld_cnt - v0, 32'd0);
      checkOutput("t3_start_count", start_cnt - s0, 32'd1);
      checkOutput("t3_stop_count", stop_cnt - p0, 32'd1);

      $display("[TB] clock stretch on write byte 0x11");
      exp_q.push_back(8'h11);
      startCond();
      writeByte(8'h54, ack);
      checkOutput("t4_addr_ack", {31'd0, ack}, {31'd0, ACK});
      ready = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         rd = 8'h11;
         applyStimulus(rd[i], bitv);
      end
      checkOutput("t4_stretch_start", {31'd0, scl_oe}, 32'd1);
      held = 0;
      for (int i = 0; i < 50; i++) begin
         waitClk(1);
         if (scl_oe === 1'b1) held++;
      end
      checkOutput("t4_stretch_held", held, 32'd50);
      ready = 1'b1;
      applyStimulus(1'b1, ack);
      checkOutput("t4_data_ack", {31'd0, ack}, {31'd0, ACK});
      checkOutput("t4_data_out", {24'd0, data_out}, 32'h11);
      stopCond();
      waitClk(4);

      $display("[TB] repeated start mid-byte");
      v0 = vld_cnt; s0 = start_cnt;
      exp_q.push_back(8'h5A);
      startCond();
      writeByte(8'h54, ack);
      checkOutput("t5_addr1_ack", {31'd0, ack}, {31'd0, ACK});
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, bitv);
      startCond();
      writeByte(8'h54, ack);
      checkOutput("t5_addr2_ack", {31'd0, ack}, {31'd0, ACK});
      writeByte(8'h5A, ack);
      checkOutput("t5_data_ack", {31'd0, ack}, {31'd0, ACK});
      stopCond();
      waitClk(4);
      checkOutput("t5_vld_count", vld_cnt - v0, 32'd1);
      checkOutput("t5_start_count", start_cnt - s0, 32'd2);

      $display("[TB] reset mid-read");
      data_in = 8'h00;
      startCond();
      writeByte(8'h55, ack);
      checkOutput("t6_addr_ack", {31'd0, ack}, {31'd0, ACK});
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, bitv);
      checkOutput("t6_sda_driven", {31'd0, sda_oe}, 32'd1);
      rstb = 1'b1;
      waitClk(1);
      checkOutput("t6_scl_released", {31'd0, scl_oe}, 32'd0);
      checkOutput("t6_sda_released", {31'd0, sda_oe}, 32'd0);
      waitClk(1);
      rstb = 1'b0;
      waitClk(1);
      checkOutput("t6_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
      checkOutput("t6_data_out", {24'd0, data_out}, 32'd0);
      checkOutput("t6_r_w", {31'd0, r_w}, 32'd0);
      checkOutput("t6_data_vld", {31'd0, data_vld}, 32'd0);
      checkOutput("t6_start", {31'd0, start}, 32'd0);
      checkOutput("t6_stop", {31'd0, stop}, 32'd0);
      scl_m = 1'b1;
      sda_m = 1'b1;
      waitClk(Q);

      checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
